// File: rtl/ppg_slot_scheduler_pkg.sv
// Shared types and constants for the PPG slot scheduler.
//   state_t  : scheduler phase encoding
//   cfg_t    : one full set of analog settings (red/IR DC_Comp + PGA, LED drive)
//   CFG_RST  : settings value after reset
package ppg_slot_scheduler_pkg;
  localparam int DC_W  = 7;
  localparam int PGA_W = 4;
  localparam int DRV_W = 4;

  localparam logic [DC_W-1:0] DC_RST = 7'd127;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RED    = 3'd1,
    ST_DARK_A = 3'd2,
    ST_IR     = 3'd3,
    ST_DARK_B = 3'd4
  } state_t;

  typedef struct packed {
    logic [DC_W-1:0]  red_dc;
    logic [PGA_W-1:0] red_pga;
    logic [DC_W-1:0]  ir_dc;
    logic [PGA_W-1:0] ir_pga;
    logic [DRV_W-1:0] drive;
  } cfg_t;

  localparam cfg_t CFG_RST = '{red_dc: DC_RST, red_pga: 4'd0,
                               ir_dc: DC_RST, ir_pga: 4'd0, drive: 4'd0};
endpackage

// File: rtl/ppg_slot_scheduler_phase_averager.sv
// Clear/accumulate/shift unit shared by all four phases.
//   clr      : start a fresh sum this cycle (phase counter 0)
//   acc      : add adc this cycle (sample window)
//   avg_next : average including this cycle's contribution, so the owner
//              can latch the phase result on the phase's last edge
module ppg_slot_scheduler_phase_averager #(
  parameter int AVG_LOG2 = 2
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       clr,
  input  logic       acc,
  input  logic [7:0] adc,
  output logic [7:0] avg_next
);
  localparam int SW = 8 + AVG_LOG2;

  logic [SW-1:0] sum, sum_next;

  always_comb begin
    sum_next = clr ? '0 : sum;
    if (acc) sum_next = sum_next + SW'(adc);
  end

  always_ff @(posedge CLK) begin
    if (rst) sum <= '0;
    else     sum <= sum_next;
  end

  assign avg_next = sum_next[SW-1:AVG_LOG2];
endmodule

// File: rtl/ppg_slot_scheduler.sv
// PPG time-slot scheduler: RED -> DARK_A -> IR -> DARK_B frames, per-phase
// settle + averaging, results published once per frame with frame_valid.
//   CLK, rst (sync, active high), enable
//   cfg_* / cfg_valid / cfg_ready : settings handshake, applied at frame start
//   ADC                           : front-end sample
//   LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain : applied analog controls
//   RED/IR/AMB_ADC_Value, frame_valid, busy       : frame results / status
module ppg_slot_scheduler
  import ppg_slot_scheduler_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_LOG2      = 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DC_W-1:0]  cfg_red_dc,
  input  logic [PGA_W-1:0] cfg_red_pga,
  input  logic [DC_W-1:0]  cfg_ir_dc,
  input  logic [PGA_W-1:0] cfg_ir_pga,
  input  logic [DRV_W-1:0] cfg_led_drive,
  input  logic [7:0]       ADC,
  output logic             LED_RED,
  output logic             LED_IR,
  output logic [DRV_W-1:0] LED_DRIVE,
  output logic [DC_W-1:0]  DC_Comp,
  output logic [PGA_W-1:0] PGA_Gain,
  output logic [7:0]       RED_ADC_Value,
  output logic [7:0]       IR_ADC_Value,
  output logic [7:0]       AMB_ADC_Value,
  output logic             frame_valid,
  output logic             busy
);
  localparam int PHASE_LEN = SETTLE_CYCLES + (1 << AVG_LOG2);
  localparam int CW        = $clog2(PHASE_LEN + 1);
  localparam logic [CW-1:0] LAST     = CW'(PHASE_LEN - 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE_CYCLES);

  state_t        state;
  logic [CW-1:0] cnt;
  cfg_t          act, pend, act_next, cfg_in;
  logic          pend_full, hs, phase_end, frame_start;
  logic [7:0]    avg_next, red_avg, ir_avg, da_avg;
  logic [8:0]    amb_sum;

  assign busy      = (state != ST_IDLE);
  assign cfg_ready = ~pend_full;
  assign hs        = cfg_valid & cfg_ready;
  assign cfg_in    = '{red_dc: cfg_red_dc, red_pga: cfg_red_pga,
                       ir_dc: cfg_ir_dc, ir_pga: cfg_ir_pga, drive: cfg_led_drive};

  assign phase_end   = busy && (cnt == LAST);
  assign frame_start = enable && ((state == ST_IDLE) || (state == ST_DARK_B && phase_end));

  // An offer accepted on the frame-start edge bypasses pending and goes live now.
  always_comb begin
    act_next = act;
    if (frame_start) begin
      if (hs)             act_next = cfg_in;
      else if (pend_full) act_next = pend;
    end
  end

  ppg_slot_scheduler_phase_averager #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .CLK      (CLK),
    .rst      (rst),
    .clr      (cnt == '0),
    .acc      (busy && (cnt >= SETTLE_C)),
    .adc      (ADC),
    .avg_next (avg_next)
  );

  // DARK_B's average is never stored: it is folded straight into AMB.
  assign amb_sum = {1'b0, da_avg} + {1'b0, avg_next};

  always_ff @(posedge CLK) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      LED_RED       <= 1'b0;
      LED_IR        <= 1'b0;
      LED_DRIVE     <= '0;
      DC_Comp       <= DC_RST;
      PGA_Gain      <= '0;
      RED_ADC_Value <= '0;
      IR_ADC_Value  <= '0;
      AMB_ADC_Value <= '0;
      frame_valid   <= 1'b0;
      act           <= CFG_RST;
      pend          <= CFG_RST;
      pend_full     <= 1'b0;
      red_avg       <= '0;
      ir_avg        <= '0;
      da_avg        <= '0;
    end else begin
      frame_valid <= 1'b0;
      act         <= act_next;
      LED_DRIVE   <= act_next.drive;

      if (frame_start) pend_full <= 1'b0;
      else if (hs) begin
        pend      <= cfg_in;
        pend_full <= 1'b1;
      end

      if (state == ST_IDLE) begin
        if (enable) begin
          state    <= ST_RED;
          cnt      <= '0;
          LED_RED  <= 1'b1;
          DC_Comp  <= act_next.red_dc;
          PGA_Gain <= act_next.red_pga;
        end
      end else if (!phase_end) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        case (state)
          ST_RED: begin
            red_avg <= avg_next;
            LED_RED <= 1'b0;
            state   <= ST_DARK_A;
          end
          ST_DARK_A: begin
            da_avg   <= avg_next;
            LED_IR   <= 1'b1;
            DC_Comp  <= act.ir_dc;
            PGA_Gain <= act.ir_pga;
            state    <= ST_IR;
          end
          ST_IR: begin
            ir_avg <= avg_next;
            LED_IR <= 1'b0;
            state  <= ST_DARK_B;
          end
          ST_DARK_B: begin
            frame_valid   <= 1'b1;
            RED_ADC_Value <= red_avg;
            IR_ADC_Value  <= ir_avg;
            AMB_ADC_Value <= amb_sum[8:1];
            if (enable) begin
              state    <= ST_RED;
              LED_RED  <= 1'b1;
              DC_Comp  <= act_next.red_dc;
              PGA_Gain <= act_next.red_pga;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ppg_slot_scheduler.sv
// Directed bench for ppg_slot_scheduler at default parameters (PHASE_LEN=8).
module tb_ppg_slot_scheduler;
  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [6:0] cfg_red_dc = '0;
  logic [3:0] cfg_red_pga = '0;
  logic [6:0] cfg_ir_dc = '0;
  logic [3:0] cfg_ir_pga = '0;
  logic [3:0] cfg_led_drive = '0;
  logic [7:0] ADC = '0;
  logic       LED_RED, LED_IR;
  logic [3:0] LED_DRIVE;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value;
  logic       frame_valid, busy;

  int total = 0;
  int bad   = 0;

  ppg_slot_scheduler dut (
    .CLK(CLK), .rst(rst), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_red_dc(cfg_red_dc), .cfg_red_pga(cfg_red_pga),
    .cfg_ir_dc(cfg_ir_dc), .cfg_ir_pga(cfg_ir_pga), .cfg_led_drive(cfg_led_drive),
    .ADC(ADC), .LED_RED(LED_RED), .LED_IR(LED_IR), .LED_DRIVE(LED_DRIVE),
    .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
    .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
    .AMB_ADC_Value(AMB_ADC_Value), .frame_valid(frame_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cfg(input int rdc, input int rpga, input int idc, input int ipga,
                         input int drv);
    cfg_red_dc    = 7'(rdc);
    cfg_red_pga   = 4'(rpga);
    cfg_ir_dc     = 7'(idc);
    cfg_ir_pga    = 4'(ipga);
    cfg_led_drive = 4'(drv);
  endtask

  // Sample stream by frame cycle k: phase = k/8, counter = k%8.
  function automatic logic [7:0] adc_val(input int mode, input int k);
    int ph, c;
    ph = k / 8;
    c  = k % 8;
    case (mode)
      0: case (ph) 0: return 8'd200; 2: return 8'd150; default: return 8'd20; endcase
      1: return (c < 4) ? 8'd255 : 8'd100;
      default: begin
        if (c < 4) return 8'd0;
        case (ph)
          0: return (c == 4) ? 8'd10 : 8'd11;
          1: return 8'd5;
          2: return (c == 4) ? 8'd7 : 8'd8;
          default: return 8'd6;
        endcase
      end
    endcase
  endfunction

  // Entered with the DUT in frame cycle 0 (first RED cycle); leaves it one
  // edge past the last DARK_B cycle, i.e. the frame_valid cycle.
  task automatic run_frame(input int mode, input int cfg_at, input int drop_at,
                           input int rst_at, input int rdc, input int rpga,
                           input int idc, input int ipga, input int drv);
    for (int k = 0; k < 32; k++) begin
      if (k == rst_at) begin
        rst    = 1'b1;
        enable = 1'b0;
        step();
        rst = 1'b0;
        return;
      end
      ADC = adc_val(mode, k);
      if (k == drop_at) enable = 1'b0;
      if (k == cfg_at) begin
        set_cfg(50, 6, 70, 7, 12);
        cfg_valid = 1'b1;
      end
      if (k == cfg_at + 1) begin
        chk("cfg_ready_drop", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
      end
      if (k == cfg_at + 2) begin
        set_cfg(1, 1, 2, 2, 3);
        cfg_valid = 1'b1;
      end
      if (k == cfg_at + 3) begin
        chk("cfg_stall_ready", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
      end
      if (k % 8 == 0) begin
        chk("led_red", int'(LED_RED), (k == 0) ? 1 : 0);
        chk("led_ir", int'(LED_IR), (k == 16) ? 1 : 0);
        chk("dc_comp", int'(DC_Comp), (k < 16) ? rdc : idc);
        chk("pga_gain", int'(PGA_Gain), (k < 16) ? rpga : ipga);
        chk("led_drive", int'(LED_DRIVE), drv);
        chk("busy", int'(busy), 1);
      end
      if (k == 0) chk("cfg_ready_frame", int'(cfg_ready), 1);
      if (k == 31) chk("no_early_fv", int'(frame_valid), 0);
      step();
    end
  endtask

  initial begin
    int fv_seen;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_led_red", int'(LED_RED), 0);
    chk("rst_led_ir", int'(LED_IR), 0);
    chk("rst_drive", int'(LED_DRIVE), 0);
    chk("rst_dc", int'(DC_Comp), 127);
    chk("rst_pga", int'(PGA_Gain), 0);
    chk("rst_red", int'(RED_ADC_Value), 0);
    chk("rst_amb", int'(AMB_ADC_Value), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);

    // Config while idle lands in pending
    set_cfg(40, 3, 60, 5, 10);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("idle_cfg_ready", int'(cfg_ready), 0);
    chk("idle_dc_kept", int'(DC_Comp), 127);

    // Frame 1: basic levels
    enable = 1'b1;
    step();
    run_frame(0, -10, -1, -1, 40, 3, 60, 5, 10);
    chk("f1_fv", int'(frame_valid), 1);
    chk("f1_red", int'(RED_ADC_Value), 200);
    chk("f1_ir", int'(IR_ADC_Value), 150);
    chk("f1_amb", int'(AMB_ADC_Value), 20);
    chk("f1_b2b_led_red", int'(LED_RED), 1);

    // Frame 2: settle rejection, config offered mid-frame (old settings hold)
    run_frame(1, 10, -1, -1, 40, 3, 60, 5, 10);
    chk("f2_fv", int'(frame_valid), 1);
    chk("f2_red", int'(RED_ADC_Value), 100);
    chk("f2_ir", int'(IR_ADC_Value), 100);
    chk("f2_amb", int'(AMB_ADC_Value), 100);

    // Frame 3: new settings from the first offer, truncation, enable drop
    run_frame(2, -10, 12, -1, 50, 6, 70, 7, 12);
    chk("f3_fv", int'(frame_valid), 1);
    chk("f3_red", int'(RED_ADC_Value), 10);
    chk("f3_ir", int'(IR_ADC_Value), 7);
    chk("f3_amb", int'(AMB_ADC_Value), 5);
    chk("f3_idle_busy", int'(busy), 0);
    chk("f3_idle_led", int'(LED_RED) + int'(LED_IR), 0);
    step();
    chk("f3_fv_once", int'(frame_valid), 0);
    step();
    step();
    chk("f3_stay_idle", int'(busy), 0);

    // Frame 4: reset at cycle 20
    enable = 1'b1;
    step();
    run_frame(0, -10, -1, 20, 50, 6, 70, 7, 12);
    chk("r_busy", int'(busy), 0);
    chk("r_led", int'(LED_RED) + int'(LED_IR), 0);
    chk("r_dc", int'(DC_Comp), 127);
    chk("r_pga", int'(PGA_Gain), 0);
    chk("r_drive", int'(LED_DRIVE), 0);
    chk("r_red", int'(RED_ADC_Value), 0);
    chk("r_ir", int'(IR_ADC_Value), 0);
    chk("r_amb", int'(AMB_ADC_Value), 0);
    chk("r_ready", int'(cfg_ready), 1);
    fv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (frame_valid) fv_seen++;
      step();
    end
    chk("r_no_fv", fv_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
